// File: rtl/ula_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package ula_pkg;

  // Arithmetic group
  localparam logic [4:0] OP_ADD        = 5'b00000;
  localparam logic [4:0] OP_ADDINC     = 5'b00001;
  localparam logic [4:0] OP_INCA       = 5'b00011;
  localparam logic [4:0] OP_SUBDEC     = 5'b00100;
  localparam logic [4:0] OP_SUB        = 5'b00101;
  localparam logic [4:0] OP_DECA       = 5'b00110;

  // Shift group
  localparam logic [4:0] OP_LSL        = 5'b01000;
  localparam logic [4:0] OP_ASR        = 5'b01001;

  // Logic, pass and constant group
  localparam logic [4:0] OP_ZEROS      = 5'b10000;
  localparam logic [4:0] OP_AND        = 5'b10001;
  localparam logic [4:0] OP_NOTA_AND_B = 5'b10010;
  localparam logic [4:0] OP_PASSB      = 5'b10011;
  localparam logic [4:0] OP_A_AND_NOTB = 5'b10100;
  localparam logic [4:0] OP_PASSA      = 5'b10101;
  localparam logic [4:0] OP_XOR        = 5'b10110;
  localparam logic [4:0] OP_OR         = 5'b10111;
  localparam logic [4:0] OP_NOR        = 5'b11000;
  localparam logic [4:0] OP_XNOR       = 5'b11001;
  localparam logic [4:0] OP_NOTA       = 5'b11010;
  localparam logic [4:0] OP_NOTA_OR_B  = 5'b11011;
  localparam logic [4:0] OP_NOTB       = 5'b11100;
  localparam logic [4:0] OP_A_OR_NOTB  = 5'b11101;
  localparam logic [4:0] OP_NAND       = 5'b11110;
  localparam logic [4:0] OP_ONES       = 5'b11111;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Assemble a flag vector so every user agrees on the bit order
  function automatic logic [3:0] packFlags(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/ula_core.sv
// Combinational execute stage: opcode + operands -> result, {N,Z,C,V}, illegal.
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o,
  output logic             illegal_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] addB;
  logic             addCin;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   lslIdx;
  logic [SHW-1:0]   asrIdx;
  logic [WIDTH-1:0] res;
  logic             cOut;
  logic             vOut;
  logic             ill;

  // All six arithmetic ops share one adder; pick the second operand and carry-in per op
  always_comb begin
    addB   = b_i;
    addCin = 1'b0;
    case (opcode_i)
      OP_ADDINC: addCin = 1'b1;
      OP_INCA: begin
        addB   = '0;
        addCin = 1'b1;
      end
      OP_SUBDEC: addB = ~b_i;
      OP_SUB: begin
        addB   = ~b_i;
        addCin = 1'b1;
      end
      OP_DECA: addB = '1;
      default: addB = b_i;
    endcase
  end

  assign sum    = {1'b0, a_i} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};
  assign amt    = b_i[SHW-1:0];
  // For a nonzero amount the last bit shifted out of lsl is a[WIDTH-amt], of asr a[amt-1]
  assign lslIdx = SHW'(0) - amt;
  assign asrIdx = amt - SHW'(1);

  // Select the result and the C/V flags; unlisted opcodes are illegal and produce zeros
  always_comb begin
    res  = '0;
    cOut = 1'b0;
    vOut = 1'b0;
    ill  = 1'b0;
    case (opcode_i)
      OP_ADD, OP_ADDINC, OP_INCA, OP_SUBDEC, OP_SUB, OP_DECA: begin
        res  = sum[WIDTH-1:0];
        cOut = sum[WIDTH];
        vOut = (a_i[WIDTH-1] == addB[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_LSL: begin
        res  = a_i << amt;
        cOut = (amt != '0) ? a_i[lslIdx] : 1'b0;
      end
      OP_ASR: begin
        res  = $unsigned($signed(a_i) >>> amt);
        cOut = (amt != '0) ? a_i[asrIdx] : 1'b0;
      end
      OP_ZEROS:      res = '0;
      OP_AND:        res = a_i & b_i;
      OP_NOTA_AND_B: res = ~a_i & b_i;
      OP_PASSB:      res = b_i;
      OP_A_AND_NOTB: res = a_i & ~b_i;
      OP_PASSA:      res = a_i;
      OP_XOR:        res = a_i ^ b_i;
      OP_OR:         res = a_i | b_i;
      OP_NOR:        res = ~a_i & ~b_i;
      OP_XNOR:       res = ~(a_i ^ b_i);
      OP_NOTA:       res = ~a_i;
      OP_NOTA_OR_B:  res = ~a_i | b_i;
      OP_NOTB:       res = ~b_i;
      OP_A_OR_NOTB:  res = a_i | ~b_i;
      OP_NAND:       res = ~a_i | ~b_i;
      OP_ONES:       res = '1;
      default:       ill = 1'b1;
    endcase
  end

  assign result_o  = res;
  assign illegal_o = ill;
  assign flags_o   = ill ? 4'b0000
                         : packFlags(res[WIDTH-1], (res == '0), cOut, vOut);

endmodule

// File: rtl/ula_pipe.sv
// Two-stage valid/ready ALU pipeline (operand register, result register) with a condition-code register.
module ula_pipe
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal,
  output logic [3:0]       ccr
);

  // Stage 1: registered operands
  logic             s1Valid_q, s1Valid_d;
  logic [4:0]       s1Op_q, s1Op_d;
  logic [WIDTH-1:0] s1A_q, s1A_d;
  logic [WIDTH-1:0] s1B_q, s1B_d;
  logic             s1Set_q, s1Set_d;

  // Stage 2: registered result
  logic             s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0] s2Result_q, s2Result_d;
  logic [3:0]       s2Flags_q, s2Flags_d;
  logic             s2Illegal_q, s2Illegal_d;
  logic             s2Set_q, s2Set_d;

  logic [3:0]       ccr_q, ccr_d;

  logic             s2Load;
  logic             s1Load;
  logic [WIDTH-1:0] coreResult;
  logic [3:0]       coreFlags;
  logic             coreIllegal;

  ula_core #(
    .WIDTH(WIDTH)
  ) uCore (
    .opcode_i (s1Op_q),
    .a_i      (s1A_q),
    .b_i      (s1B_q),
    .result_o (coreResult),
    .flags_o  (coreFlags),
    .illegal_o(coreIllegal)
  );

  // A stage may advance when it is empty or the stage after it is draining this cycle
  assign s2Load   = !s2Valid_q || out_ready;
  assign s1Load   = !s1Valid_q || s2Load;
  assign in_ready = s1Load;

  // Next-state for both pipe stages and the CCR
  always_comb begin
    s1Valid_d   = s1Valid_q;
    s1Op_d      = s1Op_q;
    s1A_d       = s1A_q;
    s1B_d       = s1B_q;
    s1Set_d     = s1Set_q;
    s2Valid_d   = s2Valid_q;
    s2Result_d  = s2Result_q;
    s2Flags_d   = s2Flags_q;
    s2Illegal_d = s2Illegal_q;
    s2Set_d     = s2Set_q;
    ccr_d       = ccr_q;
    if (s1Load) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Op_d  = opcode;
        s1A_d   = a;
        s1B_d   = b;
        s1Set_d = set_flags;
      end
    end
    if (s2Load) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Result_d  = coreResult;
        s2Flags_d   = coreFlags;
        s2Illegal_d = coreIllegal;
        s2Set_d     = s1Set_q;
      end
    end
    if (s2Valid_q && out_ready && !s2Illegal_q && s2Set_q) begin
      ccr_d = s2Flags_q;
    end
  end

  // State registers; reset empties the pipe and clears the architectural flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid_q   <= 1'b0;
      s1Op_q      <= '0;
      s1A_q       <= '0;
      s1B_q       <= '0;
      s1Set_q     <= 1'b0;
      s2Valid_q   <= 1'b0;
      s2Result_q  <= '0;
      s2Flags_q   <= '0;
      s2Illegal_q <= 1'b0;
      s2Set_q     <= 1'b0;
      ccr_q       <= '0;
    end else begin
      s1Valid_q   <= s1Valid_d;
      s1Op_q      <= s1Op_d;
      s1A_q       <= s1A_d;
      s1B_q       <= s1B_d;
      s1Set_q     <= s1Set_d;
      s2Valid_q   <= s2Valid_d;
      s2Result_q  <= s2Result_d;
      s2Flags_q   <= s2Flags_d;
      s2Illegal_q <= s2Illegal_d;
      s2Set_q     <= s2Set_d;
      ccr_q       <= ccr_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign result    = s2Result_q;
  assign flags     = s2Flags_q;
  assign illegal   = s2Illegal_q;
  assign ccr       = ccr_q;

endmodule
